// File: rtl/id_exe_stage_if.sv
// Handshake bundle between the decode stage, the ID/EXE register and the execute stage.
// The register uses the slave view; the upstream/downstream environment uses the master view.
interface id_exe_stage_if #(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_inst;
  logic [DW-1:0]  r1;
  logic [DW-1:0]  r2;
  logic [RFW-1:0] rd;

  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_inst;
  logic [DW-1:0]  r1_o;
  logic [DW-1:0]  r2_o;
  logic [RFW-1:0] rd_o;

  modport slave (
    input  in_valid, in_inst, r1, r2, rd, out_ready,
    output in_ready, out_valid, out_inst, r1_o, r2_o, rd_o
  );

  modport master (
    output in_valid, in_inst, r1, r2, rd, out_ready,
    input  in_ready, out_valid, out_inst, r1_o, r2_o, rd_o
  );
endinterface

// File: rtl/id_exe_stage.sv
// ID-to-EXE pipeline register with valid/ready handshake and synchronous flush.
// Define ID_EXE_SKID_EN for the two-entry skid variant with a registered in_ready.
module id_exe_stage #(
  parameter int            RFW      = 5,
  parameter int            DW       = 32,
  parameter int            IW       = 32,
  parameter logic [IW-1:0] NOP_INST = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  id_exe_stage_if.slave  bus
);

  typedef struct packed {
    logic [IW-1:0]  inst;
    logic [DW-1:0]  r1;
    logic [DW-1:0]  r2;
    logic [RFW-1:0] rd;
  } entry_t;

  localparam entry_t BUBBLE = '{inst: NOP_INST, r1: '0, r2: '0, rd: '0};

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef ID_EXE_SKID_EN
  localparam logic [1:0] ST_SKID  = 2'd2;
`endif

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  entry_t     r_m;
  entry_t     w_m_nxt;
  entry_t     w_in_entry;
  logic       w_in_ready;
  logic       w_in_xfer;
  logic       w_out_xfer;

  assign w_in_entry = '{inst: bus.in_inst, r1: bus.r1, r2: bus.r2, rd: bus.rd};
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = (r_state != ST_EMPTY) && bus.out_ready;

`ifdef ID_EXE_SKID_EN
  entry_t r_s;
  entry_t w_s_nxt;
  logic   r_in_ready;

  // in_ready is only a function of the registered state, so it never sees out_ready.
  assign w_in_ready = r_in_ready;

  // NOTE: every combinational output gets a default at the top of the block;
  // any path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_m_nxt     = BUBBLE;
      w_s_nxt     = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_m_nxt     = w_in_entry;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_out_xfer && w_in_xfer) begin
            w_m_nxt = w_in_entry;
          end else if (w_out_xfer) begin
            w_m_nxt     = BUBBLE;
            w_state_nxt = ST_EMPTY;
          end else if (w_in_xfer) begin
            w_s_nxt     = w_in_entry;
            w_state_nxt = ST_SKID;
          end
        end
        ST_SKID: begin
          if (w_out_xfer) begin
            w_m_nxt     = r_s;
            w_s_nxt     = '0;
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_m_nxt     = BUBBLE;
          w_s_nxt     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s        <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_s        <= w_s_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

`else
  // Single-entry mode: a held entry can be replaced in the same cycle it leaves.
  assign w_in_ready = (r_state == ST_EMPTY) || bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_m_nxt     = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_m_nxt     = w_in_entry;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in_xfer) begin
            w_m_nxt = w_in_entry;
          end else if (w_out_xfer) begin
            w_m_nxt     = BUBBLE;
            w_state_nxt = ST_EMPTY;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_m_nxt     = BUBBLE;
        end
      endcase
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering. The payload is reset as
  // well because the outputs must show NOP_INST/zeros whenever nothing is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_m     <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_inst  = r_m.inst;
  assign bus.r1_o      = r_m.r1;
  assign bus.r2_o      = r_m.r2;
  assign bus.rd_o      = r_m.rd;

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of a FIFO with capacity 1 or 2.
module tb_id_exe_stage;
  localparam int            RFW      = 5;
  localparam int            DW       = 32;
  localparam int            IW       = 32;
  localparam logic [IW-1:0] NOP_INST = 32'h0000_0013;
`ifdef ID_EXE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [IW-1:0]  inst;
    logic [DW-1:0]  r1;
    logic [DW-1:0]  r2;
    logic [RFW-1:0] rd;
  } ent_t;

  logic clk;
  logic rst_n;
  logic flush;

  id_exe_stage_if #(.RFW(RFW), .DW(DW), .IW(IW)) bus_if ();

  id_exe_stage #(.RFW(RFW), .DW(DW), .IW(IW), .NOP_INST(NOP_INST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        q[$];
  logic [31:0] obs[$];
  bit          last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stage acceptance as seen by the environment: capacity 2 with a
  // registered ready, or capacity 1 that can swap on a consuming cycle.
  function automatic bit exp_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || (bus_if.out_ready == 1'b1);
  endfunction

  task automatic model_edge();
    bit rdy;
    ent_t e;
    rdy = exp_ready();
    last_acc = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && bus_if.out_ready) void'(q.pop_front());
      if (bus_if.in_valid && rdy) begin
        e = '{inst: bus_if.in_inst, r1: bus_if.r1, r2: bus_if.r2, rd: bus_if.rd};
        q.push_back(e);
        last_acc = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    ent_t e;
    e = (q.size() > 0) ? q[0] : '{inst: NOP_INST, r1: '0, r2: '0, rd: '0};
    check("in_ready",  32'(bus_if.in_ready),  32'(exp_ready()));
    check("out_valid", 32'(bus_if.out_valid), 32'(q.size() > 0));
    check("out_inst",  bus_if.out_inst, e.inst);
    check("r1_o",      bus_if.r1_o, e.r1);
    check("r2_o",      bus_if.r2_o, e.r2);
    check("rd_o",      32'(bus_if.rd_o), 32'(e.rd));
  endtask

  // Inputs are already driven; sample mid-low-phase, then advance one edge.
  task automatic cycle();
    #1;
    check_outputs();
    if (bus_if.out_valid && bus_if.out_ready) obs.push_back(bus_if.out_inst);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] inst, input bit ordy, input bit fl);
    logic [31:0] t;
    t = inst;
    bus_if.in_valid  = v;
    bus_if.in_inst   = inst;
    bus_if.r1        = inst + 32'd1;
    bus_if.r2        = inst + 32'd2;
    bus_if.rd        = t[4:0];
    bus_if.out_ready = ordy;
    flush            = fl;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("pre_rst_valid", 32'(bus_if.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_inst",  bus_if.out_inst, NOP_INST);
    check("rst_r1",    bus_if.r1_o, 32'd0);
    check("rst_ready", 32'(bus_if.in_ready), 32'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      cycle();
      #1;
      check("stream_inst",  bus_if.out_inst, 32'h100 + 32'(i));
      check("stream_valid", 32'(bus_if.out_valid), 32'd1);
    end

    // Bubble
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
      #1;
      check("bubble_valid", 32'(bus_if.out_valid), 32'd0);
      check("bubble_inst",  bus_if.out_inst, NOP_INST);
    end

    // Backpressure
    obs.delete();
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    #1;
    check("bp_ready_22", 32'(bus_if.in_ready), 32'(SKID));
    cycle();
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    #1;
    check("bp_ready_33", 32'(bus_if.in_ready), 32'd0);
    cycle();
    last_acc = 1'b0;
    for (int k = 0; k < 5 && !last_acc; k++) begin
      drive(1'b1, 32'h33, 1'b1, 1'b0);
      cycle();
    end
    check("bp_33_taken", 32'(last_acc), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    begin
      logic [31:0] exp_seq[$];
      exp_seq = SKID ? '{32'h11, 32'h22, 32'h33} : '{32'h11, 32'h33};
      check("bp_count", 32'(obs.size()), 32'(exp_seq.size()));
      for (int k = 0; k < obs.size() && k < exp_seq.size(); k++)
        check("bp_order", obs[k], exp_seq[k]);
    end

    // Flush with simultaneous input
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h66, 1'b0, 1'b1);
    cycle();
    #1;
    check("flush_valid", 32'(bus_if.out_valid), 32'd0);
    check("flush_inst",  bus_if.out_inst, NOP_INST);
    check("flush_ready", 32'(bus_if.in_ready), 32'd1);
    obs.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    check("flush_drained", 32'(obs.size()), 32'd0);

    // Hold stability
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0);
      cycle();
      #1;
      check("hold_inst", bus_if.out_inst, 32'hDEAD);
      check("hold_r1",   bus_if.r1_o, 32'hDEAE);
      check("hold_r2",   bus_if.r2_o, 32'hDEAF);
      check("hold_rd",   32'(bus_if.rd_o), 32'h0D);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus_if.in_valid  = ($urandom_range(0, 3) != 0);
      bus_if.in_inst   = $urandom;
      bus_if.r1        = $urandom;
      bus_if.r2        = $urandom;
      bus_if.rd        = 5'($urandom);
      bus_if.out_ready = ($urandom_range(0, 2) != 0);
      flush            = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- Parametrised successor to the ID-to-EXE pipeline register.
- Adds the following on top of the plain capture register:
  - a valid/ready handshake on both sides;
  - a synchronous flush that inserts a bubble;
  - an optional skid buffer, so in_ready comes from a flop.
- Sits between the decode/register-file read stage and the execute stage.
- Carries: instruction word, two operand values, destination register index.

Parameters:
- RFW, 5: destination register index width.
- DW, 32: operand data width.
- IW, 32: instruction width.
- NOP_INST, 0: instruction word driven on out_inst when no valid entry is held (bubble/reset).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict/exception).
- in_valid  in  1  upstream has a decoded instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  IW  decoded instruction.
- r1  in  DW  operand 1.
- r2  in  DW  operand 2.
- rd  in  RFW  destination index.
- out_valid  out  1  execute-side entry valid.
- out_ready  in  1  execute stage consumes this cycle.
- out_inst  out  IW  instruction to execute.
- r1_o  out  DW  operand 1 to execute.
- r2_o  out  DW  operand 2 to execute.
- rd_o  out  RFW  destination to execute.

Behaviour:
- Transfers:
  - An input transfer occurs on a clk edge where in_valid && in_ready.
  - An output transfer occurs on a clk edge where out_valid && out_ready.
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_inst=NOP_INST, r1_o=0, r2_o=0, rd_o=0.
  - Skid entry invalid and zeroed.
  - in_ready=1 in skid mode.
  - Release is synchronised by the user; the first accept is possible on the first edge after rst_n rises.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- Order: strictly FIFO; no reordering; no entry is duplicated or dropped except by flush.
- Flush:
  - Takes effect at the clk edge where flush=1.
  - Both entries become invalid; outputs return to the reset values.
  - An input offered in the same cycle is discarded, even if in_ready was 1.
  - Flush has priority over all simultaneous transfers.
  - in_ready=1 the following cycle.
- Outputs hold stable while out_valid && !out_ready.
- Data outputs are don't-care-free: whenever out_valid=0 they show NOP_INST/zeros.
- Skid mode state machine (main register M, skid register S):
  - EMPTY (M invalid):
    - in_ready=1.
    - Input transfer -> load M -> FULL.
  - FULL (M valid, S invalid):
    - in_ready=1.
    - Output and input transfer together: M<=input, stay FULL.
    - Output only -> EMPTY.
    - Input only (out_ready=0) -> input captured into S -> SKID.
  - SKID (both valid):
    - in_ready=0.
    - Output transfer: M<=S, S invalid -> FULL.
    - No input accepted.
- Width rules: straight capture, no sign extension or truncation; all fields register together.

Optional Feature:
- Macro: ID_EXE_SKID_EN.
- Defined: two-entry skid mode as above.
  - in_ready is a registered output with no combinational path from out_ready.
  - Full throughput under continuous out_ready.
- Undefined: single register M only.
  - in_ready = !out_valid || out_ready (combinational).
  - States EMPTY/FULL only.
  - Flush and reset behaviour identical.
  - During reset in_ready=1.

Test Plan:
- Reset mid-stream:
  - Stimulus: hold out_ready=0, accept inst 0xA1, then assert rst_n=0 between edges.
  - Response: out_valid drops immediately, out_inst=NOP_INST, r1_o=0.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously, inst 0x100..0x107 with r1=inst+1, r2=inst+2, rd=inst[4:0].
  - Response: out_inst 0x100..0x107 one per cycle, 1 cycle after input, no gaps.
- Backpressure (skid):
  - Stimulus: send 0x11, 0x22, 0x33 while out_ready=0.
  - Response: 0x11 and 0x22 accepted, in_ready=0 at 0x33.
  - Then raise out_ready: outputs 0x11, 0x22, 0x33 in order.
  - With the macro undefined: only 0x11 is accepted before stall.
- Flush with simultaneous input:
  - Stimulus: stage holds 0x44 (and 0x55 in S); pulse flush=1 with in_valid=1, in_inst=0x66.
  - Response: next cycle out_valid=0, out_inst=NOP_INST, 0x66 never appears, in_ready=1.
- Hold stability:
  - Stimulus: out_valid=1 with 0xDEAD and out_ready=0 for 5 cycles while inputs toggle.
  - Response: out_inst, r1_o, r2_o, rd_o unchanged all 5 cycles.
- Bubble:
  - Stimulus: in_valid=0 for 3 cycles, out_ready=1.
  - Response: out_valid=0 and out_inst=NOP_INST for those cycles after draining.
